// File: rtl/mycpu_pkg.sv
// ----------------------------------------------------------------------------
// mycpu_pkg
// Shared types and constants for the CPU front end.
//   ADDR_W / INSTR_W : default fetch address and instruction widths
//   ifetch_state_t   : fetch-stage FSM state encoding
//   is_waiting()     : true in states that hold an outstanding memory read
// ----------------------------------------------------------------------------
package mycpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } ifetch_state_t;

  // A read is in flight (request raised, ack pending) in these two states.
  function automatic logic is_waiting(input ifetch_state_t st);
    return (st == S_FETCH) || (st == S_DRAIN);
  endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// ----------------------------------------------------------------------------
// ifetch_wdog
// Ack-timeout counter for the fetch stage.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (new wait period begins next cycle)
//   tick       : a waiting cycle passed without ack
//   expire     : this is the LIMIT-th consecutive waiting cycle without ack
// ----------------------------------------------------------------------------
module ifetch_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // Count consecutive unacknowledged waiting cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The count lags by one, so compare against LIMIT-1 to fire on the LIMIT-th cycle.
  assign expire = tick && (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch
// Instruction fetch stage: reads pc_in as fetch address, issues one
// instruction-memory read at a time and holds the result for the decoder.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   pc_in / pc_en         : current PC in; 1-cycle pulse lets pc advance
//   flush_in              : discard current/in-flight instruction, refetch
//   imem_req/addr/ack/rdata : single-outstanding memory read port
//   ir_out/ia_out/ir_valid/ir_ready : instruction handshake to the decoder
//   bus_err_out           : sticky fetch-timeout error
// Optional feature: define IFETCH_TIMEOUT_EN to enable the ack watchdog and
// the terminal S_ERR state; otherwise the stage waits for ack indefinitely.
// ----------------------------------------------------------------------------
module ifetch
  import mycpu_pkg::*;
#(
  parameter int ADDR_W         = mycpu_pkg::ADDR_W,
  parameter int INSTR_W        = mycpu_pkg::INSTR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_en,
  input  logic               flush_in,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ia_out,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               bus_err_out
);

`ifdef IFETCH_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  ifetch_state_t      state_r, state_nxt_s;
  logic [ADDR_W-1:0]  fa_r;
  logic [INSTR_W-1:0] ir_r;
  logic [ADDR_W-1:0]  ia_r;
  logic               fa_load_s;
  logic               ir_load_s;
  logic               waiting_s;
  logic               expire_s;

  assign waiting_s = is_waiting(state_r);

`ifdef IFETCH_TIMEOUT_EN
  logic wdog_clr_s;
  logic wdog_tick_s;

  // Count only while staying in the same wait state without ack; any state
  // change or ack restarts the count, which covers FETCH->DRAIN and refetches.
  assign wdog_tick_s = waiting_s && !imem_ack;
  assign wdog_clr_s  = !wdog_tick_s || (state_nxt_s != state_r);

  ifetch_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wdog_clr_s),
    .tick   (wdog_tick_s),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and load-enable decode; ack always takes precedence over expiry.
  always_comb begin
    state_nxt_s = state_r;
    fa_load_s   = 1'b0;
    ir_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        fa_load_s   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (flush_in) begin
            fa_load_s   = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            ir_load_s   = 1'b1;
            state_nxt_s = S_VALID;
          end
        end else if (expire_s) begin
          state_nxt_s = S_ERR;
        end else if (flush_in) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          fa_load_s   = 1'b1;
          state_nxt_s = S_FETCH;
        end else if (expire_s) begin
          state_nxt_s = S_ERR;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_VALID: begin
        if (flush_in || ir_ready) begin
          fa_load_s   = 1'b1;
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_VALID;
        end
      end
      S_ERR: begin
        // Terminal only when the watchdog exists; otherwise unreachable, recover.
        state_nxt_s = TIMEOUT_EN ? S_ERR : S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, fetch address and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      fa_r    <= '0;
      ir_r    <= '0;
      ia_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (fa_load_s) begin
        fa_r <= pc_in;
      end else begin
        fa_r <= fa_r;
      end
      if (ir_load_s) begin
        ir_r <= imem_rdata;
        ia_r <= fa_r;
      end else begin
        ir_r <= ir_r;
        ia_r <= ia_r;
      end
    end
  end

  // pc_en is the only combinational output: it must coincide with the accepting ack.
  assign pc_en       = ir_load_s;
  assign imem_req    = waiting_s;
  assign imem_addr   = fa_r;
  assign ir_out      = ir_r;
  assign ia_out      = ia_r;
  assign ir_valid    = (state_r == S_VALID);
  assign bus_err_out = TIMEOUT_EN && (state_r == S_ERR);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a request/hold behavioural model checked every cycle.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in;
  logic        pc_en;
  logic        flush_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic [15:0] ia_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        bus_err_out;

  int checks = 0;
  int errors = 0;
  int n_pc_en = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ifetch #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_en(pc_en), .flush_in(flush_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_out(ir_out), .ia_out(ia_out),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .bus_err_out(bus_err_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one outstanding read (possibly marked for discard) or one held instruction.
  logic        m_start, m_req, m_disc, m_hold;
  logic [15:0] m_addr, m_ir, m_ia;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start <= 1'b1; m_req <= 1'b0; m_disc <= 1'b0; m_hold <= 1'b0;
      m_addr <= 16'h0000; m_ir <= 16'h0000; m_ia <= 16'h0000;
    end else if (m_start) begin
      m_start <= 1'b0; m_req <= 1'b1; m_addr <= pc_in;
    end else if (m_req) begin
      if (imem_ack) begin
        if (!m_disc && !flush_in) begin
          m_req <= 1'b0; m_hold <= 1'b1; m_ir <= imem_rdata; m_ia <= m_addr;
        end else begin
          m_addr <= pc_in; m_disc <= 1'b0;
        end
      end else if (flush_in) begin
        m_disc <= 1'b1;
      end
    end else if (m_hold) begin
      if (flush_in || ir_ready) begin
        m_hold <= 1'b0; m_req <= 1'b1; m_addr <= pc_in;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, m_req});
      if (m_req) chk("m_imem_addr", {16'd0, imem_addr}, {16'd0, m_addr});
      chk("m_pc_en", {31'd0, pc_en}, {31'd0, (m_req && !m_disc && imem_ack && !flush_in)});
      chk("m_ir_valid", {31'd0, ir_valid}, {31'd0, m_hold});
      chk("m_ir_out", {16'd0, ir_out}, {16'd0, m_ir});
      chk("m_ia_out", {16'd0, ia_out}, {16'd0, m_ia});
      chk("m_bus_err", {31'd0, bus_err_out}, 32'd0);
      if (pc_en) n_pc_en++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; pc_in = 16'h0010; flush_in = 1'b0; imem_ack = 1'b0;
    imem_rdata = 16'h0000; ir_ready = 1'b1;
    // Reset values
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_ir_out", {16'd0, ir_out}, 32'h0000);
    chk("rst_ia_out", {16'd0, ia_out}, 32'h0000);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_out}, 32'd0);
    tick(); rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    // T1 zero-wait
    tick(); imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    @(negedge clk);
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", {16'd0, imem_addr}, 32'h0010);
    chk("t1_pc_en", {31'd0, pc_en}, 32'd1);
    tick(); imem_ack = 1'b0; pc_in = 16'h0011;
    @(negedge clk);
    chk("t1_valid", {31'd0, ir_valid}, 32'd1);
    chk("t1_ir", {16'd0, ir_out}, 32'hA5A5);
    chk("t1_ia", {16'd0, ia_out}, 32'h0010);
    chk("t1_noreq", {31'd0, imem_req}, 32'd0);
    tick(); ir_ready = 1'b0;
    // T2 wait states: three request cycles without ack
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_req", {31'd0, imem_req}, 32'd1);
      chk("t2_addr", {16'd0, imem_addr}, 32'h0011);
      chk("t2_no_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    @(negedge clk);
    chk("t2_pc_en", {31'd0, pc_en}, 32'd1);
    tick(); imem_ack = 1'b0; pc_in = 16'h0012;
    // T3 backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", {31'd0, ir_valid}, 32'd1);
      chk("t3_ir", {16'd0, ir_out}, 32'h1234);
      chk("t3_ia", {16'd0, ia_out}, 32'h0011);
      chk("t3_noreq", {31'd0, imem_req}, 32'd0);
      chk("t3_no_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    ir_ready = 1'b1;
    tick(); ir_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("t4_fetch_addr", {16'd0, imem_addr}, 32'h0012);
    tick(); imem_ack = 1'b0; pc_in = 16'h0013;
    // T4 flush in S_VALID
    @(negedge clk);
    chk("t4_valid", {31'd0, ir_valid}, 32'd1);
    tick(); flush_in = 1'b1; pc_in = 16'h0200;
    @(negedge clk);
    chk("t4_flush_no_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); flush_in = 1'b0;
    @(negedge clk);
    chk("t4_valid_drop", {31'd0, ir_valid}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", {16'd0, imem_addr}, 32'h0200);
    // T5 flush while waiting, repeated flush in drain
    tick(); flush_in = 1'b1; pc_in = 16'h0300;
    @(negedge clk);
    chk("t5_no_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_drain_req", {31'd0, imem_req}, 32'd1);
    chk("t5_drain_addr", {16'd0, imem_addr}, 32'h0200);
    tick(); flush_in = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("t5_drain_ack_no_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); imem_ack = 1'b0;
    @(negedge clk);
    chk("t5_no_valid", {31'd0, ir_valid}, 32'd0);
    chk("t5_refetch", {16'd0, imem_addr}, 32'h0300);
    // Ack coinciding with flush in S_FETCH
    tick(); imem_ack = 1'b1; flush_in = 1'b1; pc_in = 16'h0400; imem_rdata = 16'h5555;
    @(negedge clk);
    chk("ackflush_no_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); imem_ack = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    chk("ackflush_refetch", {16'd0, imem_addr}, 32'h0400);
    chk("ackflush_no_valid", {31'd0, ir_valid}, 32'd0);
    // Address boundary 16'hFFFF passes through unchanged
    tick(); imem_ack = 1'b1; imem_rdata = 16'h1111; ir_ready = 1'b1;
    tick(); imem_ack = 1'b0; pc_in = 16'hFFFF;
    @(negedge clk);
    chk("b_ir", {16'd0, ir_out}, 32'h1111);
    tick(); imem_ack = 1'b1; imem_rdata = 16'h2222;
    @(negedge clk);
    chk("b_addr_ffff", {16'd0, imem_addr}, 32'hFFFF);
    tick(); imem_ack = 1'b0; pc_in = 16'h0000;
    @(negedge clk);
    chk("b_ia_ffff", {16'd0, ia_out}, 32'hFFFF);
    tick();
    @(negedge clk);
    chk("b_addr_0000", {16'd0, imem_addr}, 32'h0000);
    // Asynchronous reset mid-fetch
    #2; rst_n = 1'b0; #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_ir", {16'd0, ir_out}, 32'h0000);
    chk("arst_ia", {16'd0, ia_out}, 32'h0000);
    tick(); rst_n = 1'b1; pc_in = 16'h0050;
    @(negedge clk);
    chk("arst_idle_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_ack = 1'b1; imem_rdata = 16'h3333;
    @(negedge clk);
    chk("arst_addr", {16'd0, imem_addr}, 32'h0050);
    tick(); imem_ack = 1'b0;
    @(negedge clk);
    chk("arst_ir_new", {16'd0, ir_out}, 32'h3333);
    chk("pc_en_total", n_pc_en, 32'd6);
`ifdef IFETCH_TIMEOUT_EN
    // T6 timeout with TIMEOUT_CYCLES=4
    chk_en = 1'b0;
    tick(); rst_n = 1'b0; pc_in = 16'h0600;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_req", {31'd0, imem_req}, 32'd1);
      chk("t6_no_err", {31'd0, bus_err_out}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("t6_err", {31'd0, bus_err_out}, 32'd1);
    chk("t6_req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("t6_err_sticky", {31'd0, bus_err_out}, 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_err", {31'd0, bus_err_out}, 32'd0);
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    tick(); rst_n = 1'b1;
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
